// File: rtl/module_prio_sel.sv
// module_prio_sel: picks which stage (operand k or product) drives the display, on the latest listo rise
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   num_op, sig_op    - packed operand magnitudes (W_OP each) and their sign bits
//   listo_op          - per-operand ready levels
//   num_mul, sig_mul  - product magnitude and sign
//   listo             - product ready level
//   numero_output     - registered selected magnitude (operands zero-extended)
//   signo_output      - registered selected sign
//   sel_output        - current source: 0 none, k+1 operand k, N_OPS+1 product
//   cambio            - one-cycle pulse when source or magnitude changed
module module_prio_sel #(
    parameter int N_OPS = 2,
    parameter int W_OP  = 8,
    parameter int W_RES = 16,
    parameter bit TRACK = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_OPS*W_OP-1:0]      num_op,
    input  logic [N_OPS-1:0]           sig_op,
    input  logic [N_OPS-1:0]           listo_op,
    input  logic [W_RES-1:0]           num_mul,
    input  logic                       sig_mul,
    input  logic                       listo,
    output logic [W_RES-1:0]           numero_output,
    output logic                       signo_output,
    output logic [$clog2(N_OPS+2)-1:0] sel_output,
    output logic                       cambio
);
    localparam int SW = $clog2(N_OPS + 2);
    localparam logic [SW-1:0] SEL_MUL = SW'(N_OPS + 1);

    if (W_RES < W_OP) begin : g_bad_width
        $error("module_prio_sel: W_RES must be >= W_OP");
    end

    logic [N_OPS-1:0] prev_op_q;
    logic             prev_mul_q;
    logic [W_RES-1:0] num_q, num_d;
    logic             sgn_q, sgn_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             cambio_q;
    logic [N_OPS-1:0] rise_op;
    logic             rise_mul;

    assign rise_op  = listo_op & ~prev_op_q;
    assign rise_mul = listo & ~prev_mul_q;

    // Tracking is applied first so any rise this cycle overrides it; ascending
    // operand loop makes the highest-index rise win, and the product beats all.
    always_comb begin
        num_d = num_q;
        sgn_d = sgn_q;
        sel_d = sel_q;
        if (TRACK) begin
            if (sel_q == SEL_MUL && listo) begin
                num_d = num_mul;
                sgn_d = sig_mul;
            end
            for (int i = 0; i < N_OPS; i++)
                if (sel_q == SW'(i + 1) && listo_op[i]) begin
                    num_d = W_RES'(num_op[i*W_OP +: W_OP]);
                    sgn_d = sig_op[i];
                end
        end
        for (int i = 0; i < N_OPS; i++)
            if (rise_op[i]) begin
                num_d = W_RES'(num_op[i*W_OP +: W_OP]);
                sgn_d = sig_op[i];
                sel_d = SW'(i + 1);
            end
        if (rise_mul) begin
            num_d = num_mul;
            sgn_d = sig_mul;
            sel_d = SEL_MUL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_op_q  <= '0;
            prev_mul_q <= 1'b0;
            num_q      <= '0;
            sgn_q      <= 1'b0;
            sel_q      <= '0;
            cambio_q   <= 1'b0;
        end else begin
            prev_op_q  <= listo_op;
            prev_mul_q <= listo;
            num_q      <= num_d;
            sgn_q      <= sgn_d;
            sel_q      <= sel_d;
            cambio_q   <= (num_d != num_q) || (sel_d != sel_q);
        end
    end

    assign numero_output = num_q;
    assign signo_output  = sgn_q;
    assign sel_output    = sel_q;
    assign cambio        = cambio_q;
endmodule

// File: tb/tb_module_prio_sel.sv
// tb_module_prio_sel: TRACK=0 and TRACK=1 selectors on shared stimulus vs a reference model
module tb_module_prio_sel;
    localparam int N = 2;
    localparam int WO = 8;
    localparam int WR = 16;

    logic          clk, rst;
    logic [N*WO-1:0] num_op;
    logic [N-1:0]  sig_op, listo_op;
    logic [WR-1:0] num_mul;
    logic          sig_mul, listo;
    logic [WR-1:0] num0, num1;
    logic          sgn0, sgn1, chg0, chg1;
    logic [1:0]    sel0, sel1;

    int n_cmp = 0;
    int n_err = 0;

    int          m_sel [2];
    logic [WR-1:0] m_num [2];
    logic        m_sgn [2];
    logic        m_chg [2];
    logic [N-1:0] pv_op;
    logic        pv_mul;

    module_prio_sel #(.N_OPS(N), .W_OP(WO), .W_RES(WR), .TRACK(0)) u_t0 (
        .clk(clk), .rst(rst), .num_op(num_op), .sig_op(sig_op), .listo_op(listo_op),
        .num_mul(num_mul), .sig_mul(sig_mul), .listo(listo),
        .numero_output(num0), .signo_output(sgn0), .sel_output(sel0), .cambio(chg0)
    );

    module_prio_sel #(.N_OPS(N), .W_OP(WO), .W_RES(WR), .TRACK(1)) u_t1 (
        .clk(clk), .rst(rst), .num_op(num_op), .sig_op(sig_op), .listo_op(listo_op),
        .num_mul(num_mul), .sig_mul(sig_mul), .listo(listo),
        .numero_output(num1), .signo_output(sgn1), .sel_output(sel1), .cambio(chg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Source s: 1..N is operand s-1, N+1 is the product.
    function automatic logic [WR:0] src_val(int s);
        if (s == N + 1) return {sig_mul, num_mul};
        return {sig_op[s-1], {(WR-WO){1'b0}}, num_op[(s-1)*WO +: WO]};
    endfunction

    function automatic logic src_lvl(int s);
        return (s == N + 1) ? listo : listo_op[s-1];
    endfunction

    task automatic model_step();
        int w;
        logic [WR:0] v;
        logic [WR-1:0] on;
        int os;
        w = 0;
        for (int k = 0; k < N; k++) if (listo_op[k] && !pv_op[k]) w = k + 1;
        if (listo && !pv_mul) w = N + 1;
        for (int t = 0; t < 2; t++) begin
            on = m_num[t];
            os = m_sel[t];
            if (rst) begin
                m_num[t] = '0; m_sgn[t] = 1'b0; m_sel[t] = 0;
            end else if (w != 0) begin
                v = src_val(w);
                m_num[t] = v[WR-1:0]; m_sgn[t] = v[WR]; m_sel[t] = w;
            end else if (t == 1 && m_sel[t] != 0 && src_lvl(m_sel[t])) begin
                v = src_val(m_sel[t]);
                m_num[t] = v[WR-1:0]; m_sgn[t] = v[WR];
            end
            m_chg[t] = !rst && (m_num[t] != on || m_sel[t] != os);
        end
        pv_op  = rst ? '0 : listo_op;
        pv_mul = rst ? 1'b0 : listo;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("t0_num", 32'(num0), 32'(m_num[0]));
        chk("t0_sgn", 32'(sgn0), 32'(m_sgn[0]));
        chk("t0_sel", 32'(sel0), 32'(m_sel[0]));
        chk("t0_cambio", 32'(chg0), 32'(m_chg[0]));
        chk("t1_num", 32'(num1), 32'(m_num[1]));
        chk("t1_sgn", 32'(sgn1), 32'(m_sgn[1]));
        chk("t1_sel", 32'(sel1), 32'(m_sel[1]));
        chk("t1_cambio", 32'(chg1), 32'(m_chg[1]));
    endtask

    task automatic do_reset();
        listo_op = '0; listo = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic base_data();
        num_op = {8'd10, 8'd15}; sig_op = 2'b10; num_mul = 16'd150; sig_mul = 1'b1;
    endtask

    initial begin
        for (int t = 0; t < 2; t++) begin
            m_sel[t] = 0; m_num[t] = '0; m_sgn[t] = 1'b0; m_chg[t] = 1'b0;
        end
        pv_op = '0; pv_mul = 1'b0;
        rst = 1'b1; listo_op = '0; listo = 1'b0;
        base_data();
        cyc();
        cyc();
        chk("reset_num", 32'(num0), 32'd0);
        chk("reset_sel", 32'(sel0), 32'd0);
        chk("reset_cambio", 32'(chg0), 32'd0);
        rst = 1'b0;

        // sequenced stages
        listo_op[0] = 1'b1; cyc();
        chk("seq_op0_num", 32'(num0), 32'd15);
        chk("seq_op0_sel", 32'(sel0), 32'd1);
        chk("seq_op0_cambio", 32'(chg0), 32'd1);
        cyc(); cyc();
        listo_op[1] = 1'b1; cyc();
        chk("seq_op1_num", 32'(num0), 32'd10);
        chk("seq_op1_sel", 32'(sel0), 32'd2);
        chk("seq_op1_sgn", 32'(sgn0), 32'd1);
        cyc(); cyc();
        listo = 1'b1; cyc();
        chk("seq_mul_num", 32'(num0), 32'd150);
        chk("seq_mul_sel", 32'(sel0), 32'd3);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("seq_stable_num", 32'(num0), 32'd150);
            chk("seq_stable_cambio", 32'(chg0), 32'd0);
        end

        // simultaneous rises
        do_reset();
        listo_op = 2'b11; listo = 1'b1; cyc();
        chk("sim_all_sel", 32'(sel0), 32'd3);
        chk("sim_all_num", 32'(num0), 32'd150);
        cyc();
        chk("sim_all_cambio_once", 32'(chg0), 32'd0);
        do_reset();
        listo_op = 2'b11; cyc();
        chk("sim_ops_sel", 32'(sel0), 32'd2);
        chk("sim_ops_num", 32'(num0), 32'd10);

        // held level, TRACK=0 holds and TRACK=1 follows
        do_reset();
        listo_op = 2'b01; cyc();
        num_op[7:0] = 8'd99; cyc();
        chk("held_t0_num", 32'(num0), 32'd15);
        chk("held_t0_cambio", 32'(chg0), 32'd0);
        chk("held_t1_num", 32'(num1), 32'd99);
        chk("held_t1_cambio", 32'(chg1), 32'd1);
        cyc();
        chk("held_t1_cambio_once", 32'(chg1), 32'd0);

        // re-rise of product
        base_data();
        listo = 1'b1; cyc();
        listo = 1'b0; cyc();
        listo = 1'b1; num_mul = 16'd200; cyc();
        chk("rerise_num", 32'(num0), 32'd200);
        chk("rerise_sel", 32'(sel0), 32'd3);
        chk("rerise_cambio", 32'(chg0), 32'd1);

        // reset mid-operation with listo held high
        listo = 1'b0; cyc();
        num_mul = 16'd150; listo = 1'b1; cyc();
        chk("rstmid_pre_num", 32'(num0), 32'd150);
        rst = 1'b1; cyc();
        chk("rstmid_num", 32'(num0), 32'd0);
        chk("rstmid_sel", 32'(sel0), 32'd0);
        rst = 1'b0; cyc();
        chk("rstmid_after_num", 32'(num0), 32'd150);
        chk("rstmid_after_sel", 32'(sel0), 32'd3);
        chk("rstmid_after_cambio", 32'(chg0), 32'd1);

        // width: zero-extension of full-scale operand
        do_reset();
        num_op[7:0] = 8'hFF; listo_op = 2'b01; cyc();
        chk("width_num", 32'(num0), 32'h00FF);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < N; k++) if ($urandom_range(0, 3) == 0) listo_op[k] = ~listo_op[k];
            if ($urandom_range(0, 3) == 0) listo = ~listo;
            if ($urandom_range(0, 1) == 0) num_op = N*WO'($urandom);
            if ($urandom_range(0, 1) == 0) num_mul = WR'($urandom);
            sig_op = N'($urandom);
            sig_mul = 1'($urandom);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/module_prio_sel.md
# module_prio_sel

Parametrised display-source selector for the multiplier datapath: it takes N operand channels and the product, and decides which value drives the display path. It registers the selected magnitude and sign and reports the selected source. It acts on the rising edge of each stage's `listo` flag, so the most recently completed stage always owns the display. It sits between the operand-capture / multiplier blocks and the 7-segment conversion logic.

## Interface
Parameters:
- `N_OPS`, default 2: number of operand channels (range 1..7).
- `W_OP`, default 8: operand magnitude width.
- `W_RES`, default 16: product and output magnitude width. `W_RES >= W_OP` is required; elaboration errors otherwise.
- `TRACK`, default 0: update mode for the owning source.
  - 0: latch the value only on the rising edge of that source's `listo`.
  - 1: also follow the owning source's live data while its `listo` stays high.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, all state on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `num_op` in N_OPS*W_OP: packed operand magnitudes; channel k occupies bits [k*W_OP +: W_OP].
- `sig_op` in N_OPS: operand sign bits (1 = negative).
- `listo_op` in N_OPS: per-operand ready levels.
- `num_mul` in W_RES: product magnitude.
- `sig_mul` in 1: product sign.
- `listo` in 1: product ready level.
- `numero_output` out W_RES: selected magnitude, registered.
- `signo_output` out 1: selected sign, registered.
- `sel_output` out $clog2(N_OPS+2): current source.
  - 0 = none.
  - k+1 = operand k.
  - N_OPS+1 = product.
- `cambio` out 1: one-cycle pulse when `sel_output` or `numero_output` changes.

## Operation
- Edge detection:
  - Registers `prev_op[N_OPS-1:0]` and `prev_mul` hold the previous-cycle levels.
  - A rise on channel i is `listo_i & ~prev_i`.
- States: IDLE (source 0), OP_k (source k+1), RES (source N_OPS+1). Any state moves to any other state on a rise.
- Priority when several rises happen in the same cycle:
  - The product rise wins.
  - Otherwise the highest-index operand wins.
  - The losing rises are discarded and do not queue.
- Actions on a winning rise:
  - Operand k: load the slice zero-extended to W_RES, `signo_output <= sig_op[k]`, `sel_output <= k+1`.
  - Product: load `num_mul` and `sig_mul`, `sel_output <= N_OPS+1`.
- A rise on the source that already owns the display reloads its current data. A second rise needs the level to fall and then rise again.
- With TRACK=1 and no rise this cycle:
  - If the owning source's `listo` is high, output its live data.
  - If that level has fallen, hold the last value. Falling never changes state.
- With TRACK=0 and no rise: hold all outputs.
- `cambio` is 1 in the cycle after any register update that changes `sel_output` or `numero_output`. It stays 0 when a reload leaves both unchanged. The sign alone does not trigger it.
- IDLE is entered only through reset. No input sequence returns the block to IDLE.

## Timing
- Reset values: `numero_output`=0, `signo_output`=0, `sel_output`=0, `cambio`=0, all `prev_*`=0.
- `rst` overrides every other input in the same cycle.
- Latency:
  - A `listo` level that is first high at clock edge t causes an output update at edge t.
  - The output is visible from t until t+1, which is one cycle of registered latency.
  - `cambio` is high in the same window as the update.
- Reset mid-operation:
  - Outputs clear at the next edge.
  - Because `prev_*` clears, any `listo` still high after `rst` drops counts as a fresh rise on the first cycle after reset.
  - That rise is then resolved by the normal priority rules.
- Levels held high produce no further events: exactly one rise per low-to-high transition.
- There is no combinational path from any input to any output.

## Test plan
All scenarios use N_OPS=2, W_OP=8, W_RES=16, TRACK=0 unless stated.
- Sequenced stages:
  - Stimulus: after reset, `num_op`={8'd10,8'd15}, `sig_op`=2'b10, `num_mul`=150, `sig_mul`=1. Then `listo_op[0]`↑, +2 cycles `listo_op[1]`↑, +2 cycles `listo`↑, all levels held.
  - Response: `numero_output` 15/sel 1/sign 0, then 10/sel 2/sign 1, then 150/sel 3/sign 1. One `cambio` pulse each; stable for 10 cycles afterwards.
- Simultaneous rises:
  - Stimulus: `listo_op`=2'b11 and `listo`=1 in the same cycle.
  - Response: sel 3, output 150, exactly one `cambio`.
  - Repeat with `listo_op`=2'b11 only: sel 2, output 10.
- Held level, no retrigger:
  - Stimulus: `listo_op[0]` stays high while `num_op[0]` changes 15 to 99.
  - Response: TRACK=0 output stays 15 with no `cambio`. TRACK=1 output goes to 99 one cycle later with one `cambio`.
- Re-rise:
  - Stimulus: drop `listo` for 1 cycle and raise it with `num_mul`=200.
  - Response: output 200, sel 3, one `cambio`.
- Reset mid-operation:
  - Stimulus: in RES with output 150, pulse `rst` for 1 cycle while `listo` stays high.
  - Response: outputs are all 0 for the reset cycle, then output 150/sel 3 on the next edge with `cambio`=1.
- Width check:
  - Stimulus: operand 8'hFF.
  - Response: `numero_output`=16'h00FF, upper bits zero.
